wb_stage: RTL and testbench

- Registered writeback stage for the RV32I core. It generalises the plain combinational writeback mux.
- Selects the register-file write data from ALU result, load data, PC+4 or immediate.
- Sign/zero-extends sub-word loads and stalls the core while load data is outstanding.
- Sits between the execute/memory datapath and the register file write port.

---
 rtl/wb_stage.sv | 134 +++++++++++++
 tb/tb_wb_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Registered RV32I writeback stage: source select, load extension, load-wait stall.
// Optional load-data timeout is compiled in with `define WB_TIMEOUT_EN.
module wb_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         wb_sel,
    input  logic [XLEN-1:0]    alu_res,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    imm,
    input  logic [RADDR_W-1:0] rd,
    input  logic               reg_we,
    input  logic [2:0]         ld_funct3,
    input  logic [1:0]         ld_addr_lo,
    input  logic               mem_rvalid,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               stall,
    output logic               ld_err
);

    typedef enum logic [0:0] {IDLE, WAIT_MEM} state_t;

    state_t             state_reg;
    logic [RADDR_W-1:0] rd_reg;
    logic               reg_we_reg;
    logic [2:0]         funct3_reg;
    logic [1:0]         addr_lo_reg;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_reg;
`endif

    logic [2:0]         f3_sel;
    logic [1:0]         lo_sel;
    logic signed [7:0]  byte_lane;
    logic signed [15:0] half_lane;
    logic signed [31:0] word_lane;
    logic [XLEN-1:0]    ld_data;
    logic [XLEN-1:0]    wb_data;

    assign in_ready = (state_reg == IDLE);
    assign stall    = (state_reg == WAIT_MEM);

    // While waiting, the load is decoded from the fields captured at request time.
    always_comb begin
        f3_sel    = (state_reg == WAIT_MEM) ? funct3_reg  : ld_funct3;
        lo_sel    = (state_reg == WAIT_MEM) ? addr_lo_reg : ld_addr_lo;
        byte_lane = mem_rdata[{lo_sel, 3'b000} +: 8];
        half_lane = mem_rdata[{lo_sel[1], 4'b0000} +: 16];
        word_lane = mem_rdata[31:0];
        case (f3_sel)
            3'b000:  ld_data = XLEN'(byte_lane);
            3'b001:  ld_data = XLEN'(half_lane);
            3'b100:  ld_data = XLEN'($unsigned(byte_lane));
            3'b101:  ld_data = XLEN'($unsigned(half_lane));
            default: ld_data = XLEN'(word_lane);
        endcase
        case (wb_sel)
            2'b01:   wb_data = alu_res;
            2'b10:   wb_data = pc + XLEN'(4);
            2'b11:   wb_data = imm;
            default: wb_data = ld_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rd_reg      <= '0;
            reg_we_reg  <= 1'b0;
            funct3_reg  <= '0;
            addr_lo_reg <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            ld_err      <= 1'b0;
`ifdef WB_TIMEOUT_EN
            cnt_reg     <= '0;
`endif
        end else begin
            rf_we  <= 1'b0;
            ld_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (wb_sel != 2'b00 || mem_rvalid) begin
                            rf_we    <= reg_we && (rd != '0);
                            rf_waddr <= rd;
                            rf_wdata <= wb_data;
                        end else begin
                            rd_reg      <= rd;
                            reg_we_reg  <= reg_we;
                            funct3_reg  <= ld_funct3;
                            addr_lo_reg <= ld_addr_lo;
                            state_reg   <= WAIT_MEM;
`ifdef WB_TIMEOUT_EN
                            cnt_reg     <= '0;
`endif
                        end
                    end
                end
                WAIT_MEM: begin
                    // Data arriving on the final timeout cycle still completes the load.
                    if (mem_rvalid) begin
                        rf_we     <= reg_we_reg && (rd_reg != '0);
                        rf_waddr  <= rd_reg;
                        rf_wdata  <= ld_data;
                        state_reg <= IDLE;
`ifdef WB_TIMEOUT_EN
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        ld_err    <= 1'b1;
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed writeback cases then randomized traffic.
module tb_wb_stage;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  wb_sel;
    logic [31:0] alu_res, pc, imm, mem_rdata;
    logic [4:0]  rd;
    logic        reg_we;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        mem_rvalid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall;
    logic        ld_err;

    wb_stage #(.XLEN(32), .RADDR_W(5), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .wb_sel(wb_sel), .alu_res(alu_res), .pc(pc), .imm(imm), .rd(rd),
        .reg_we(reg_we), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall(stall), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          err_cyc = -1;
    bit          waiting = 0;
    logic [4:0]  p_rd;
    bit          p_we;
    logic [2:0]  p_f3;
    logic [1:0]  p_lo;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        longint unsigned b, h;
        b = (longint'(w) >> (8 * lo)) % 256;
        h = (longint'(w) >> (16 * (lo / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    // Monitor: every write pulse must match the head of the scoreboard, in the predicted cycle.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h required no write",
                         cyc, rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || rf_waddr !== e.addr || rf_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                             cyc, rf_waddr, rf_wdata, e.cyc, e.addr, e.data);
                end else
                    $display("write cyc=%0d addr=%0d data=%h ok", cyc, rf_waddr, rf_wdata);
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_write cyc=%0d rf_we=%b required write addr=%0d data=%h",
                     cyc, rf_we, exp_q[0].addr, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        if (ld_err !== 1'b0 || cyc == err_cyc) begin
            checks++;
            if (ld_err !== (cyc == err_cyc)) begin
                errors++;
                $display("FAIL ld_err cyc=%0d actual=%b required=%b", cyc, ld_err, cyc == err_cyc);
            end else
                $display("ld_err pulse cyc=%0d ok", cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.cyc  = cyc + 1;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; the model predicts the write (if any) one cycle later.
    task automatic step(input bit v, input logic [1:0] sel, input logic [31:0] a,
                        input logic [31:0] p, input logic [31:0] im, input logic [4:0] r,
                        input bit we, input logic [2:0] f3, input logic [1:0] lo,
                        input bit rv, input logic [31:0] rdata,
                        input bit has_lit, input logic [31:0] lit);
        logic [31:0] d;
        @(posedge clk);
        #1;
        in_valid = v; wb_sel = sel; alu_res = a; pc = p; imm = im; rd = r;
        reg_we = we; ld_funct3 = f3; ld_addr_lo = lo; mem_rvalid = rv; mem_rdata = rdata;
        check("in_ready", 32'(in_ready), 32'(!waiting));
        check("stall", 32'(stall), 32'(waiting));
        if (!waiting && v) begin
            if (sel != 2'b00 || rv) begin
                case (sel)
                    2'b01:   d = a;
                    2'b10:   d = p + 32'd4;
                    2'b11:   d = im;
                    default: d = ref_load(f3, lo, rdata);
                endcase
                if (has_lit) d = lit;
                if (we && r != 0) push(r, d);
            end else begin
                waiting = 1;
                p_rd = r; p_we = we; p_f3 = f3; p_lo = lo;
            end
        end else if (waiting && rv) begin
            d = has_lit ? lit : ref_load(p_f3, p_lo, rdata);
            if (p_we && p_rd != 0) push(p_rd, d);
            waiting = 0;
        end
    endtask

    task automatic idle(input bit rv, input logic [31:0] rdata);
        step(0, 2'b00, 0, 0, 0, 0, 0, 3'd2, 0, rv, rdata, 0, 0);
    endtask

    task automatic op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] p,
                      input logic [31:0] im, input logic [4:0] r, input logic [31:0] lit);
        step(1, sel, a, p, im, r, 1, 3'd2, 0, 0, 32'h0, 1, lit);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] r,
                      input logic [31:0] lit);
        step(1, 2'b00, 0, 0, 0, r, 1, f3, lo, 1, 32'h80FF_7F01, 1, lit);
    endtask

    initial begin
        int wait_cnt;
        rst = 1; in_valid = 0; wb_sel = 0; alu_res = 0; pc = 0; imm = 0; rd = 0;
        reg_we = 0; ld_funct3 = 0; ld_addr_lo = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rf_we", 32'(rf_we), 0);
        check("reset_rf_waddr", 32'(rf_waddr), 0);
        check("reset_rf_wdata", rf_wdata, 0);
        check("reset_ld_err", 32'(ld_err), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_stall", 32'(stall), 0);
        rst = 0;

        op(2'b01, 32'h0000_1234, 0, 0, 5'd5, 32'h0000_1234);
        idle(0, 0);
        op(2'b10, 0, 32'h0000_0100, 0, 5'd6, 32'h0000_0104);
        op(2'b10, 0, 32'hFFFF_FFFC, 0, 5'd7, 32'h0000_0000);
        op(2'b10, 0, 32'hFFFF_FFFF, 0, 5'd8, 32'h0000_0003);
        op(2'b11, 0, 0, 32'hABCD_E000, 5'd9, 32'hABCD_E000);

        ld(3'd0, 2'd2, 5'd10, 32'hFFFF_FFFF);
        ld(3'd4, 2'd3, 5'd11, 32'h0000_0080);
        ld(3'd1, 2'd2, 5'd12, 32'hFFFF_80FF);
        ld(3'd5, 2'd0, 5'd13, 32'h0000_7F01);
        ld(3'd2, 2'd0, 5'd14, 32'h80FF_7F01);
        ld(3'd1, 2'd3, 5'd15, 32'hFFFF_80FF);

        // Delayed LW; the ALU request offered during the stall must vanish.
        step(1, 2'b00, 0, 0, 0, 5'd16, 1, 3'd2, 0, 0, 32'hDEAD_BEEF, 0, 0);
        step(1, 2'b01, 32'h7777_7777, 0, 0, 5'd17, 1, 3'd2, 0, 0, 0, 0, 0);
        idle(0, 32'hDEAD_BEEF);
        idle(1, 32'h1234_5678);
        idle(0, 0);

        op(2'b01, 32'h0000_4321, 0, 0, 5'd0, 0);
        op(2'b01, 32'h0000_0055, 0, 0, 5'd18, 32'h0000_0055);

        // Reset in the middle of a load wait abandons it.
        step(1, 2'b00, 0, 0, 0, 5'd19, 1, 3'd0, 0, 0, 0, 0, 0);
        idle(0, 0);
        @(posedge clk);
        #2 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        waiting = 0;
        check("rst_stall", 32'(stall), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        idle(1, 32'hFFFF_FFFF);
        idle(0, 0);

`ifdef WB_TIMEOUT_EN
        step(1, 2'b00, 0, 0, 0, 5'd20, 1, 3'd2, 0, 0, 0, 0, 0);
        err_cyc = cyc + TIMEOUT + 1;
        repeat (TIMEOUT) idle(0, 0);
        waiting = 0;
        idle(0, 0);
        idle(0, 0);
`endif

        wait_cnt = 0;
        repeat (400) begin
            bit v, rv;
            logic [1:0] sel;
            v  = ($urandom_range(3) != 0);
            sel = 2'($urandom_range(3));
            if (waiting) begin
                wait_cnt++;
                rv = ($urandom_range(2) == 0) || (wait_cnt >= 8);
            end else begin
                wait_cnt = 0;
                rv = $urandom_range(1) == 1;
            end
            step(v, sel, $urandom, $urandom, $urandom,
                 ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)),
                 $urandom_range(3) != 0, 3'($urandom_range(7)), 2'($urandom_range(3)),
                 rv, $urandom, 0, 0);
        end
        if (waiting) idle(1, $urandom);
        repeat (3) idle(0, 0);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
